// File: rtl/branch_predict_sched.sv
// Branch prediction scheduler: issues predictor lookups for fetch, tracks them in an
// in-order in-flight queue, and replays recorded predictions to the renew port on resolve.
module branch_predict_sched #(
    parameter int DEPTH     = 8,
    parameter int TAG_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic                 resp_taken,
    output logic [TAG_WIDTH-1:0] resp_tag,
    input  logic                 resolve_valid,
    input  logic                 resolve_taken,
    output logic                 resolve_error,
    output logic                 flush,
    output logic [TAG_WIDTH:0]   count,
    output logic                 predict_valid,
    input  logic                 predict_result,
    output logic                 renew_valid,
    output logic                 last_predict,
    output logic                 renew_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [TAG_WIDTH:0] FULL = (TAG_WIDTH+1)'(DEPTH);

    state_t               state;
    state_t               state_nxt;
    logic [DEPTH-1:0]     queue;
    logic [TAG_WIDTH-1:0] wr_ptr;
    logic [TAG_WIDTH-1:0] rd_ptr;
    logic                 resolve_ok;
    logic                 mispredict;
    logic                 push;
    logic                 pop;

    // Resolves in FLUSH belong to the squashed wrong path and are dropped without error.
    assign resolve_ok = resolve_valid && (state != FLUSH) && (count != '0);
    assign mispredict = resolve_ok && (queue[rd_ptr] != resolve_taken);
    assign push       = (state == WAIT) && !mispredict;
    assign pop        = resolve_ok && !mispredict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    state_nxt = FLUSH;
                end else if (predict_valid) begin
                    state_nxt = WAIT;
                end
            end
            WAIT:    state_nxt = mispredict ? FLUSH : IDLE;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Requests stall while a resolve or its renew is in progress so lookups see updated history.
    always_comb begin
        req_ready     = (state == IDLE) && (count < FULL) && !resolve_valid && !renew_valid;
        predict_valid = req_valid && req_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            queue         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            resp_valid    <= 1'b0;
            resp_taken    <= 1'b0;
            resp_tag      <= '0;
            renew_valid   <= 1'b0;
            last_predict  <= 1'b0;
            renew_result  <= 1'b0;
            flush         <= 1'b0;
            resolve_error <= 1'b0;
        end else begin
            resp_valid    <= 1'b0;
            renew_valid   <= 1'b0;
            flush         <= 1'b0;
            resolve_error <= 1'b0;

            if (resolve_valid && (state != FLUSH) && (count == '0)) begin
                resolve_error <= 1'b1;
            end

            if (resolve_ok) begin
                renew_valid  <= 1'b1;
                last_predict <= queue[rd_ptr];
                renew_result <= resolve_taken;
            end

            if (mispredict) begin
                flush  <= 1'b1;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    queue[wr_ptr] <= predict_result;
                    resp_valid    <= 1'b1;
                    resp_taken    <= predict_result;
                    resp_tag      <= wr_ptr;
                    wr_ptr        <= wr_ptr + TAG_WIDTH'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + TAG_WIDTH'(1);
                end
                count <= count + (TAG_WIDTH+1)'(push) - (TAG_WIDTH+1)'(pop);
            end
        end
    end

endmodule
